// File: rtl/axi_pkg.sv
// Shared AXI4 field widths, encodings, default-configuration payload structs and
// width helpers used to size the per-channel register slices.
package axi_pkg;

    localparam int unsigned LEN_W    = 8;
    localparam int unsigned SIZE_W   = 3;
    localparam int unsigned BURST_W  = 2;
    localparam int unsigned LOCK_W   = 1;
    localparam int unsigned CACHE_W  = 4;
    localparam int unsigned PROT_W   = 3;
    localparam int unsigned QOS_W    = 4;
    localparam int unsigned REGION_W = 4;
    localparam int unsigned RESP_W   = 2;
    localparam int unsigned LAST_W   = 1;

    localparam int unsigned DEF_ID_W   = 4;
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_USER_W = 1;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_ADDR_W-1:0] addr;
        logic [LEN_W-1:0]      len;
        logic [SIZE_W-1:0]     size;
        logic [BURST_W-1:0]    burst;
        logic [LOCK_W-1:0]     lock;
        logic [CACHE_W-1:0]    cache;
        logic [PROT_W-1:0]     prot;
        logic [QOS_W-1:0]      qos;
        logic [REGION_W-1:0]   region;
        logic [DEF_USER_W-1:0] user;
    } aw_t;

    typedef aw_t ar_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_DATA_W/8-1:0] strb;
        logic [LAST_W-1:0]       last;
        logic [DEF_USER_W-1:0]   user;
    } w_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [RESP_W-1:0]     resp;
        logic [DEF_USER_W-1:0] user;
    } b_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_DATA_W-1:0] data;
        logic [RESP_W-1:0]     resp;
        logic [LAST_W-1:0]     last;
        logic [DEF_USER_W-1:0] user;
    } r_t;

    function automatic int unsigned ax_width(int unsigned id_w, int unsigned addr_w,
                                             int unsigned user_w);
        return id_w + addr_w + LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W + PROT_W
               + QOS_W + REGION_W + user_w;
    endfunction

    function automatic int unsigned w_width(int unsigned data_w, int unsigned user_w);
        return data_w + data_w / 8 + LAST_W + user_w;
    endfunction

    function automatic int unsigned b_width(int unsigned id_w, int unsigned user_w);
        return id_w + RESP_W + user_w;
    endfunction

    function automatic int unsigned r_width(int unsigned id_w, int unsigned data_w,
                                            int unsigned user_w);
        return id_w + data_w + RESP_W + LAST_W + user_w;
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry register slice: main register drives the output, skid register catches
// the beat accepted while the output stalls. Input ready is a flop (skid empty).
module axi_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic             main_valid_n;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] main_data_n;
    logic             skid_valid;
    logic             skid_valid_n;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] skid_data_n;
    logic             ready_q;
    logic             ready_n;
    logic             in_fire;
    logic             main_free;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            main_valid <= main_valid_n;
            main_data  <= main_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            ready_q    <= ready_n;
        end
    end

    // Main slot refills from skid first (oldest beat), else from the input.
    always_comb begin
        main_valid_n = main_valid;
        main_data_n  = main_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;
        in_fire      = in_valid & ready_q;
        main_free    = ~main_valid | out_ready;
        if (main_free) begin
            if (skid_valid) begin
                main_valid_n = 1'b1;
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
            end else if (in_fire) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
        end
        ready_n = ~skid_valid_n;
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: rtl/axi_interface.sv
// AXI4 full register slice: five independent skid-buffered channels, forward for
// AW/W/AR and reverse for B/R, each with one cycle of latency.
module axi_interface
    import axi_pkg::*;
#(
    parameter int unsigned ID_W   = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned USER_W = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ID_W-1:0]   s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic [7:0]        s_axi_awlen,
    input  logic [2:0]        s_axi_awsize,
    input  logic [1:0]        s_axi_awburst,
    input  logic              s_axi_awlock,
    input  logic [3:0]        s_axi_awcache,
    input  logic [2:0]        s_axi_awprot,
    input  logic [3:0]        s_axi_awqos,
    input  logic [3:0]        s_axi_awregion,
    input  logic [USER_W-1:0] s_axi_awuser,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    input  logic              s_axi_wlast,
    input  logic [USER_W-1:0] s_axi_wuser,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [ID_W-1:0]   s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic [USER_W-1:0] s_axi_buser,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ID_W-1:0]   s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic [7:0]        s_axi_arlen,
    input  logic [2:0]        s_axi_arsize,
    input  logic [1:0]        s_axi_arburst,
    input  logic              s_axi_arlock,
    input  logic [3:0]        s_axi_arcache,
    input  logic [2:0]        s_axi_arprot,
    input  logic [3:0]        s_axi_arqos,
    input  logic [3:0]        s_axi_arregion,
    input  logic [USER_W-1:0] s_axi_aruser,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [ID_W-1:0]   s_axi_rid,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic [USER_W-1:0] s_axi_ruser,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ID_W-1:0]   m_axi_awid,
    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [7:0]        m_axi_awlen,
    output logic [2:0]        m_axi_awsize,
    output logic [1:0]        m_axi_awburst,
    output logic              m_axi_awlock,
    output logic [3:0]        m_axi_awcache,
    output logic [2:0]        m_axi_awprot,
    output logic [3:0]        m_axi_awqos,
    output logic [3:0]        m_axi_awregion,
    output logic [USER_W-1:0] m_axi_awuser,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic              m_axi_wlast,
    output logic [USER_W-1:0] m_axi_wuser,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [ID_W-1:0]   m_axi_bid,
    input  logic [1:0]        m_axi_bresp,
    input  logic [USER_W-1:0] m_axi_buser,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ID_W-1:0]   m_axi_arid,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arlock,
    output logic [3:0]        m_axi_arcache,
    output logic [2:0]        m_axi_arprot,
    output logic [3:0]        m_axi_arqos,
    output logic [3:0]        m_axi_arregion,
    output logic [USER_W-1:0] m_axi_aruser,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [ID_W-1:0]   m_axi_rid,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic [USER_W-1:0] m_axi_ruser,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int unsigned AX_W = ax_width(ID_W, ADDR_W, USER_W);
    localparam int unsigned W_W  = w_width(DATA_W, USER_W);
    localparam int unsigned B_W  = b_width(ID_W, USER_W);
    localparam int unsigned R_W  = r_width(ID_W, DATA_W, USER_W);

    logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_W-1:0]  w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [R_W-1:0]  r_in, r_out;

    // Flatten each channel payload; fields pass through uninterpreted.
    assign aw_in = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                    s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                    s_axi_awregion, s_axi_awuser};
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos,
            m_axi_awregion, m_axi_awuser} = aw_out;
    assign ar_in = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                    s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                    s_axi_arregion, s_axi_aruser};
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos,
            m_axi_arregion, m_axi_aruser} = ar_out;
    assign w_in = {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser};
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser} = w_out;
    assign b_in = {m_axi_bid, m_axi_bresp, m_axi_buser};
    assign {s_axi_bid, s_axi_bresp, s_axi_buser} = b_out;
    assign r_in = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser};
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_ruser} = r_out;

    axi_skid_buffer #(.WIDTH(AX_W)) u_aw (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(s_axi_awvalid), .in_ready(s_axi_awready), .in_data(aw_in),
        .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data(aw_out)
    );

    axi_skid_buffer #(.WIDTH(W_W)) u_w (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data(w_in),
        .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out)
    );

    axi_skid_buffer #(.WIDTH(AX_W)) u_ar (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(s_axi_arvalid), .in_ready(s_axi_arready), .in_data(ar_in),
        .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data(ar_out)
    );

    axi_skid_buffer #(.WIDTH(B_W)) u_b (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(m_axi_bvalid), .in_ready(m_axi_bready), .in_data(b_in),
        .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out)
    );

    axi_skid_buffer #(.WIDTH(R_W)) u_r (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(m_axi_rvalid), .in_ready(m_axi_rready), .in_data(r_in),
        .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out)
    );

endmodule

// File: tb/tb_axi_interface.sv
// Directed bench for axi_interface: reset, write/read bursts, streaming,
// backpressure and mid-burst reset, with hand-computed expectations.
module tb_axi_interface;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned USER_W = 1;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    logic [ID_W-1:0]   s_axi_awid, m_axi_awid, s_axi_arid, m_axi_arid;
    logic [ADDR_W-1:0] s_axi_awaddr, m_axi_awaddr, s_axi_araddr, m_axi_araddr;
    logic [7:0]        s_axi_awlen, m_axi_awlen, s_axi_arlen, m_axi_arlen;
    logic [2:0]        s_axi_awsize, m_axi_awsize, s_axi_arsize, m_axi_arsize;
    logic [1:0]        s_axi_awburst, m_axi_awburst, s_axi_arburst, m_axi_arburst;
    logic              s_axi_awlock, m_axi_awlock, s_axi_arlock, m_axi_arlock;
    logic [3:0]        s_axi_awcache, m_axi_awcache, s_axi_arcache, m_axi_arcache;
    logic [2:0]        s_axi_awprot, m_axi_awprot, s_axi_arprot, m_axi_arprot;
    logic [3:0]        s_axi_awqos, m_axi_awqos, s_axi_arqos, m_axi_arqos;
    logic [3:0]        s_axi_awregion, m_axi_awregion, s_axi_arregion, m_axi_arregion;
    logic [USER_W-1:0] s_axi_awuser, m_axi_awuser, s_axi_aruser, m_axi_aruser;
    logic              s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
    logic              s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
    logic [DATA_W-1:0] s_axi_wdata, m_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb, m_axi_wstrb;
    logic              s_axi_wlast, m_axi_wlast;
    logic [USER_W-1:0] s_axi_wuser, m_axi_wuser;
    logic              s_axi_wvalid, s_axi_wready, m_axi_wvalid, m_axi_wready;
    logic [ID_W-1:0]   s_axi_bid, m_axi_bid;
    logic [1:0]        s_axi_bresp, m_axi_bresp;
    logic [USER_W-1:0] s_axi_buser, m_axi_buser;
    logic              s_axi_bvalid, s_axi_bready, m_axi_bvalid, m_axi_bready;
    logic [ID_W-1:0]   s_axi_rid, m_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata, m_axi_rdata;
    logic [1:0]        s_axi_rresp, m_axi_rresp;
    logic              s_axi_rlast, m_axi_rlast;
    logic [USER_W-1:0] s_axi_ruser, m_axi_ruser;
    logic              s_axi_rvalid, s_axi_rready, m_axi_rvalid, m_axi_rready;

    int unsigned checks = 0;
    int unsigned errors = 0;

    axi_interface #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .USER_W(USER_W)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awlock(s_axi_awlock), .s_axi_awcache(s_axi_awcache),
        .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arlock(s_axi_arlock), .s_axi_arcache(s_axi_arcache),
        .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
        .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int unsigned exp_q[$];
        int unsigned sent, recv, drops;
        logic [31:0] exp_word;
        bit dropped;

        aresetn = 1'b0;
        {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
         s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion, s_axi_awuser} = '0;
        {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock,
         s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion, s_axi_aruser} = '0;
        {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser} = '0;
        {m_axi_bid, m_axi_bresp, m_axi_buser} = '0;
        {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser} = '0;
        s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0; m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b0;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = 32'hDEAD_BEEF;

        // Reset: everything idle and zero even with an input valid presented
        step(); step();
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_bready", 64'(m_axi_bready), 64'd0);
        chk("rst_rready", 64'(m_axi_rready), 64'd0);
        chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        chk("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
        chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("rst_rdata", 64'(s_axi_rdata), 64'd0);
        s_axi_awvalid = 1'b0;
        s_axi_awaddr  = '0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("rel_awready_pre", 64'(s_axi_awready), 64'd0);
        step();
        chk("rel_awready", 64'(s_axi_awready), 64'd1);
        chk("rel_wready", 64'(s_axi_wready), 64'd1);
        chk("rel_arready", 64'(s_axi_arready), 64'd1);
        chk("rel_bready", 64'(m_axi_bready), 64'd1);
        chk("rel_rready", 64'(m_axi_rready), 64'd1);
        chk("rel_awvalid", 64'(m_axi_awvalid), 64'd0);

        // Write burst: AW id=3 addr=10 size=2 len=6, seven W beats
        s_axi_awvalid = 1'b1; s_axi_awid = 4'd3; s_axi_awaddr = 32'd10;
        s_axi_awsize = 3'd2; s_axi_awlen = 8'd6; s_axi_awburst = 2'd1; s_axi_awuser = 1'b1;
        for (int i = 0; i < 7; i++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = 32'hC0DE_0000 + 32'(i);
            s_axi_wstrb  = 4'hF ^ 4'(i);
            s_axi_wlast  = (i == 6);
            s_axi_wuser  = 1'(i);
            step();
            if (i == 0) begin
                s_axi_awvalid = 1'b0;
                chk("wr_awvalid", 64'(m_axi_awvalid), 64'd1);
                chk("wr_awid", 64'(m_axi_awid), 64'd3);
                chk("wr_awaddr", 64'(m_axi_awaddr), 64'd10);
                chk("wr_awlen", 64'(m_axi_awlen), 64'd6);
                chk("wr_awsize", 64'(m_axi_awsize), 64'd2);
                chk("wr_awuser", 64'(m_axi_awuser), 64'd1);
            end
            if (i == 1) chk("wr_aw_drained", 64'(m_axi_awvalid), 64'd0);
            chk("wr_wvalid", 64'(m_axi_wvalid), 64'd1);
            chk("wr_wdata", 64'(m_axi_wdata), 64'(32'hC0DE_0000 + 32'(i)));
            chk("wr_wstrb", 64'(m_axi_wstrb), 64'(4'hF ^ 4'(i)));
            chk("wr_wlast", 64'(m_axi_wlast), 64'(i == 6));
            chk("wr_wuser", 64'(m_axi_wuser), 64'(i % 2));
        end
        s_axi_wvalid = 1'b0;
        step();
        chk("wr_w_idle", 64'(m_axi_wvalid), 64'd0);
        m_axi_bvalid = 1'b1; m_axi_bid = 4'd3; m_axi_bresp = 2'b01;
        step();
        m_axi_bvalid = 1'b0;
        chk("wr_bvalid", 64'(s_axi_bvalid), 64'd1);
        chk("wr_bid", 64'(s_axi_bid), 64'd3);
        chk("wr_bresp", 64'(s_axi_bresp), 64'd1);
        step();
        chk("wr_b_idle", 64'(s_axi_bvalid), 64'd0);

        // Read burst: AR id=5 addr=0x100 len=3, four R beats 0xA0..0xA3
        s_axi_arvalid = 1'b1; s_axi_arid = 4'd5; s_axi_araddr = 32'h100; s_axi_arlen = 8'd3;
        step();
        s_axi_arvalid = 1'b0;
        chk("rd_arvalid", 64'(m_axi_arvalid), 64'd1);
        chk("rd_arid", 64'(m_axi_arid), 64'd5);
        chk("rd_araddr", 64'(m_axi_araddr), 64'h100);
        chk("rd_arlen", 64'(m_axi_arlen), 64'd3);
        for (int i = 0; i < 4; i++) begin
            m_axi_rvalid = 1'b1; m_axi_rid = 4'd5; m_axi_rresp = 2'b11;
            m_axi_rdata  = 32'hA0 + 32'(i);
            m_axi_rlast  = (i == 3);
            step();
            chk("rd_rvalid", 64'(s_axi_rvalid), 64'd1);
            chk("rd_rid", 64'(s_axi_rid), 64'd5);
            chk("rd_rdata", 64'(s_axi_rdata), 64'(32'hA0 + 32'(i)));
            chk("rd_rresp", 64'(s_axi_rresp), 64'd3);
            chk("rd_rlast", 64'(s_axi_rlast), 64'(i == 3));
        end
        m_axi_rvalid = 1'b0;
        step();
        chk("rd_r_idle", 64'(s_axi_rvalid), 64'd0);

        // Back-to-back: 16 beats in 16 consecutive cycles
        drops = 0;
        s_axi_wstrb = 4'hF; s_axi_wuser = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!s_axi_wready) drops++;
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = 32'h200 + 32'(i);
            s_axi_wlast  = (i == 15);
            step();
            chk("b2b_wvalid", 64'(m_axi_wvalid), 64'd1);
            chk("b2b_wdata", 64'(m_axi_wdata), 64'(32'h200 + 32'(i)));
        end
        if (!s_axi_wready) drops++;
        chk("b2b_ready_drops", 64'(drops), 64'd0);
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        step();
        chk("b2b_idle", 64'(m_axi_wvalid), 64'd0);

        // Backpressure: m_axi_wready low for cycles 0..4 while streaming 10 beats
        sent = 0; recv = 0; dropped = 1'b0;
        for (int cyc = 0; cyc < 40 && (sent < 10 || exp_q.size() != 0); cyc++) begin
            m_axi_wready  = (cyc >= 5);
            s_axi_wvalid  = (sent < 10);
            s_axi_wdata   = 32'h300 + 32'(sent);
            s_axi_awvalid = (cyc == 2);
            s_axi_awaddr  = 32'h55;
            if (cyc >= 1 && cyc <= 4) begin
                chk("bp_stable_valid", 64'(m_axi_wvalid), 64'd1);
                chk("bp_stable_data", 64'(m_axi_wdata), 64'h300);
            end
            if (cyc == 3) begin
                chk("bp_aw_indep_valid", 64'(m_axi_awvalid), 64'd1);
                chk("bp_aw_indep_addr", 64'(m_axi_awaddr), 64'h55);
            end
            if (!s_axi_wready && !dropped) begin
                dropped = 1'b1;
                chk("bp_accept_before_drop", 64'(sent), 64'd2);
            end
            if (m_axi_wvalid && m_axi_wready) begin
                exp_word = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
                chk("bp_order", 64'(m_axi_wdata), 64'(exp_word));
                recv++;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                exp_q.push_back(32'h300 + sent);
                sent++;
            end
            step();
        end
        s_axi_wvalid = 1'b0; s_axi_awvalid = 1'b0;
        chk("bp_sent", 64'(sent), 64'd10);
        chk("bp_recv", 64'(recv), 64'd10);
        chk("bp_dropped", 64'(dropped), 64'd1);
        chk("bp_idle", 64'(m_axi_wvalid), 64'd0);
        chk("bp_ready_back", 64'(s_axi_wready), 64'd1);

        // Mid-burst reset with two beats buffered
        m_axi_wready = 1'b0;
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h400;
        step();
        s_axi_wdata = 32'h401;
        step();
        s_axi_wvalid = 1'b0;
        chk("mr_full_valid", 64'(m_axi_wvalid), 64'd1);
        chk("mr_full_ready", 64'(s_axi_wready), 64'd0);
        aresetn = 1'b0;
        #1;
        chk("mr_wvalid", 64'(m_axi_wvalid), 64'd0);
        chk("mr_wdata", 64'(m_axi_wdata), 64'd0);
        chk("mr_awready", 64'(s_axi_awready), 64'd0);
        chk("mr_arready", 64'(s_axi_arready), 64'd0);
        chk("mr_bready", 64'(m_axi_bready), 64'd0);
        chk("mr_rready", 64'(m_axi_rready), 64'd0);
        step();
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("mr_rel_pre", 64'(s_axi_wready), 64'd0);
        step();
        chk("mr_rel_ready", 64'(s_axi_wready), 64'd1);
        chk("mr_no_stale", 64'(m_axi_wvalid), 64'd0);
        m_axi_wready = 1'b1;
        step();
        chk("mr_no_stale_late", 64'(m_axi_wvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
